// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// The operands are split into NUM_STAGES carry segments. Each stage adds one
// segment using the carry registered by the stage before it. The last stage
// is the output register.
module pipelined_addsub #(
  parameter int unsigned ADDER_WIDTH = 32,
  parameter int unsigned NUM_STAGES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pas_in_valid,
  output logic                   pas_in_ready,
  input  logic [ADDER_WIDTH-1:0] pas_a_in,
  input  logic [ADDER_WIDTH-1:0] pas_b_in,
  input  logic                   pas_sub_in,
  output logic                   pas_out_valid,
  input  logic                   pas_out_ready,
  output logic [ADDER_WIDTH-1:0] pas_sum,
  output logic                   pas_cout,
  output logic                   pas_ovf
);

  localparam int unsigned SegW = ADDER_WIDTH / NUM_STAGES;
  localparam int unsigned Last = NUM_STAGES - 1;
  localparam int unsigned Msb  = ADDER_WIDTH - 1;

  // Effective B: inverted for subtract, with the +1 supplied as segment-0 carry-in.
  logic [ADDER_WIDTH-1:0] eff_b;
  logic                   adv;

  // Per-stage inputs: what each stage consumes this cycle.
  logic [ADDER_WIDTH-1:0] op_a    [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] op_b    [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] base    [NUM_STAGES];
  logic                   cin     [NUM_STAGES];
  logic                   vin     [NUM_STAGES];
  logic                   amsb_in [NUM_STAGES];
  logic                   bmsb_in [NUM_STAGES];
  logic [SegW:0]          seg     [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] sum_d   [NUM_STAGES];

  // Per-stage registers. Operand registers hold the unconsumed segments
  // shifted down, so the next segment to add always sits in the low bits.
  logic                   valid_q [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] sum_q   [NUM_STAGES];
  logic                   carry_q [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] a_q     [NUM_STAGES];
  logic [ADDER_WIDTH-1:0] b_q     [NUM_STAGES];
  logic                   a_msb_q [NUM_STAGES];
  logic                   b_msb_q [NUM_STAGES];

  assign eff_b = pas_sub_in ? ~pas_b_in : pas_b_in;

  // Whole pipeline moves together whenever the output register can be vacated.
  assign adv          = ~valid_q[Last] | pas_out_ready;
  assign pas_in_ready = adv;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign op_a[s]    = pas_a_in;
      assign op_b[s]    = eff_b;
      assign base[s]    = '0;
      assign cin[s]     = pas_sub_in;
      assign vin[s]     = pas_in_valid;
      assign amsb_in[s] = pas_a_in[Msb];
      assign bmsb_in[s] = eff_b[Msb];
    end else begin : g_tail
      assign op_a[s]    = a_q[s-1];
      assign op_b[s]    = b_q[s-1];
      assign base[s]    = sum_q[s-1];
      assign cin[s]     = carry_q[s-1];
      assign vin[s]     = valid_q[s-1];
      assign amsb_in[s] = a_msb_q[s-1];
      assign bmsb_in[s] = b_msb_q[s-1];
    end

    assign seg[s] = {1'b0, op_a[s][SegW-1:0]} + {1'b0, op_b[s][SegW-1:0]}
                  + {{SegW{1'b0}}, cin[s]};

    // Higher segments of the partial sum are still zero, so OR places segment s.
    assign sum_d[s] = base[s] | (ADDER_WIDTH'(seg[s][SegW-1:0]) << (s * SegW));
  end

  // Pipeline registers: shift all stages on adv, hold otherwise; bubbles kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        valid_q[i] <= 1'b0;
        sum_q[i]   <= '0;
        carry_q[i] <= 1'b0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        a_msb_q[i] <= 1'b0;
        b_msb_q[i] <= 1'b0;
      end
    end else if (adv) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        valid_q[i] <= vin[i];
        sum_q[i]   <= sum_d[i];
        carry_q[i] <= seg[i][SegW];
        a_q[i]     <= op_a[i] >> SegW;
        b_q[i]     <= op_b[i] >> SegW;
        a_msb_q[i] <= amsb_in[i];
        b_msb_q[i] <= bmsb_in[i];
      end
    end
  end

  assign pas_out_valid = valid_q[Last];
  assign pas_sum       = sum_q[Last];
  assign pas_cout      = carry_q[Last];
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign pas_ovf       = (a_msb_q[Last] == b_msb_q[Last]) &&
                         (sum_q[Last][Msb] != a_msb_q[Last]);

endmodule
